// File: rtl/robo_wall_follower.sv
// rtl/robo_wall_follower.sv - left-hand wall-following decision FSM for the pipe-inspection robot
module robo_wall_follower (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic avancar,
    output logic girar,
    output logic remover
);

    typedef enum logic [2:0] {
        SEEK     = 3'd0,
        FOLLOW   = 3'd1,
        TURN_ADV = 3'd2,
        ROT2     = 3'd3,
        ROT1     = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t r_state;
    logic   r_moved;
    logic   w_pipe_end;

    // The black start cell is ignored until the robot has advanced at least once.
    assign w_pipe_end = under & r_moved;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= SEEK;
            r_moved <= 1'b0;
            avancar <= 1'b0;
            girar   <= 1'b0;
            remover <= 1'b0;
        end else begin
            avancar <= 1'b0;
            girar   <= 1'b0;
            remover <= 1'b0;
            case (r_state)
                SEEK, FOLLOW, TURN_ADV: begin
                    if (w_pipe_end) begin
                        r_state <= DONE;
                    end else if (barrier) begin
                        remover <= 1'b1;
                    end else if (r_state == FOLLOW && !left) begin
                        girar   <= 1'b1;
                        r_state <= TURN_ADV;
                    end else if (head) begin
                        girar   <= 1'b1;
                        r_state <= ROT2;
                    end else begin
                        // TURN_ADV commits to one step forward so open space cannot cause spinning.
                        avancar <= 1'b1;
                        r_moved <= 1'b1;
                        if (r_state == TURN_ADV) begin
                            r_state <= FOLLOW;
                        end
                    end
                end
                ROT2: begin
                    girar   <= 1'b1;
                    r_state <= ROT1;
                end
                ROT1: begin
                    girar   <= 1'b1;
                    r_state <= FOLLOW;
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= SEEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_robo_wall_follower.sv
// tb/tb_robo_wall_follower.sv - table-driven scoreboard bench for robo_wall_follower
module tb_robo_wall_follower;

    logic clock;
    logic reset;
    logic head;
    logic left;
    logic under;
    logic barrier;
    logic avancar;
    logic girar;
    logic remover;

    typedef struct {
        logic       rst_n;
        logic       h;
        logic       l;
        logic       u;
        logic       b;
        logic [2:0] exp;
        string      name;
    } step_t;

    step_t      vec[$];
    logic [2:0] sb[$];
    int         n_cmp;
    int         n_err;

    localparam logic [2:0] ADV = 3'b100;
    localparam logic [2:0] ROT = 3'b010;
    localparam logic [2:0] REM = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

    robo_wall_follower dut (
        .clock   (clock),
        .reset   (reset),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .avancar (avancar),
        .girar   (girar),
        .remover (remover)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic r, input logic h, input logic l, input logic u,
                       input logic b, input logic [2:0] e, input string nm);
        step_t s;
        s.rst_n = r; s.h = h; s.l = l; s.u = u; s.b = b; s.exp = e; s.name = nm;
        vec.push_back(s);
    endtask

    task automatic check(input logic [2:0] exp, input string nm);
        logic [2:0] act;
        act = {avancar, girar, remover};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {avancar,girar,remover}=%b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_table();
        logic [2:0] e;
        foreach (vec[i]) begin
            @(negedge clock);
            reset   = vec[i].rst_n;
            head    = vec[i].h;
            left    = vec[i].l;
            under   = vec[i].u;
            barrier = vec[i].b;
            sb.push_back(vec[i].exp);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL %s: scoreboard empty", vec[i].name);
            end else begin
                e = sb.pop_front();
                check(e, vec[i].name);
            end
        end
        vec.delete();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;

        // reset held low with random sensors
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), NONE, "reset_low");
        add(1, 0, 0, 0, 0, ADV,  "seek_adv");
        add(1, 1, 0, 0, 0, ROT,  "seek_rot2");
        add(1, 0, 0, 0, 0, ROT,  "rot2_rot1");
        add(1, 0, 0, 0, 0, ROT,  "rot1_follow");
        add(1, 0, 1, 0, 0, ADV,  "follow_adv1");
        add(1, 0, 1, 0, 0, ADV,  "follow_adv2");
        add(1, 0, 0, 0, 0, ROT,  "follow_corner");
        add(1, 0, 0, 0, 0, ADV,  "turnadv_adv_noleft");
        add(1, 0, 1, 0, 0, ADV,  "follow_again");
        add(1, 0, 0, 0, 0, ROT,  "follow_corner2");
        add(1, 0, 0, 0, 1, REM,  "turnadv_barrier");
        add(1, 1, 0, 0, 0, ROT,  "turnadv_head_rot2");
        add(1, 0, 0, 0, 0, ROT,  "turnadv_rot1");
        add(1, 0, 0, 0, 0, ROT,  "turnadv_to_follow");
        for (int k = 0; k < 4; k++)
            add(1, 0, 1, 0, 1, REM, "follow_remove");
        add(1, 0, 1, 0, 0, ADV,  "follow_after_remove");
        add(1, 1, 1, 0, 0, ROT,  "follow_head_rot2");
        add(1, 0, 1, 0, 1, ROT,  "rot2_ignores_barrier");
        add(1, 0, 1, 0, 0, ROT,  "rot1_to_follow");
        add(1, 0, 1, 0, 0, ADV,  "follow_adv3");
        add(1, 0, 1, 1, 0, NONE, "pipe_end_done");
        add(1, 0, 0, 0, 0, NONE, "done_idle");
        add(1, 1, 0, 0, 0, NONE, "done_ignores_head");
        add(1, 0, 0, 0, 1, NONE, "done_ignores_barrier");
        add(0, 0, 0, 0, 0, NONE, "reset_from_done");
        add(1, 0, 0, 1, 0, ADV,  "start_cell_ignored");
        add(1, 0, 0, 1, 1, NONE, "done_over_barrier");
        add(0, 0, 0, 0, 0, NONE, "reset_again");
        add(1, 0, 0, 0, 1, REM,  "seek_barrier");
        add(1, 0, 0, 0, 0, ADV,  "seek_resume");
        add(1, 1, 0, 0, 0, ROT,  "seek_rot2_b");
        add(1, 0, 0, 0, 0, ROT,  "rot2_rot1_b");
        run_table();

        // asynchronous reset mid-ROT1, away from any clock edge
        #2;
        reset = 1'b0;
        #1;
        check(NONE, "async_reset_rot1");

        add(0, 1, 1, 0, 0, NONE, "held_reset");
        add(1, 1, 0, 0, 0, ROT,  "fresh_rot_1");
        add(1, 0, 0, 0, 0, ROT,  "fresh_rot_2");
        add(1, 0, 0, 0, 0, ROT,  "fresh_rot_3");
        add(1, 0, 1, 0, 0, ADV,  "fresh_follow_adv");
        run_table();

        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
